// File: rtl/contador_pkg.sv
// ---------------------------------------------------------------------------
// contador_pkg
// Shared definitions for the BCD up/down counter slice.
//   - BCD_MAX / BCD_MIN : digit limits used for carry/borrow detection
//   - bcd_t             : one 4-bit BCD decade
//   - SEG7_TABLE        : active-high 7-segment patterns, bit order gfedcba
//   - bcd_clamp()       : forces an out-of-range digit (10..15) to 9
//   - seg7_decode()     : table lookup that blanks non-BCD codes
// No ports (package).
// ---------------------------------------------------------------------------
package contador_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    localparam logic [6:0] SEG7_TABLE [0:9] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111101,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1101111   // 9
    };

    // Loaded digits above 9 are saturated so the register never holds
    // a non-decimal code.
    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    // Non-BCD codes cannot appear in the counter, but blank them anyway
    // so the lookup never indexes outside the table.
    function automatic logic [6:0] seg7_decode(input bcd_t d);
        logic [6:0] pattern;
        pattern = 7'b0000000;
        for (int i = 0; i < 10; i++) begin
            if (d == bcd_t'(i)) begin
                pattern = SEG7_TABLE[i];
            end
        end
        return pattern;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// ---------------------------------------------------------------------------
// bcd_digit
// One decade of the BCD counter. Holds its own digit register and reports
// a carry (counting up from 9) or borrow (counting down from 0) to the next
// decade combinationally, so a ripple across all decades settles within a
// single clock edge.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   step_in     : step request from the previous decade (or count enable)
//   up          : 1 = increment, 0 = decrement
//   load        : synchronous load strobe (overrides stepping)
//   ld_digit    : digit to load (saturated to 9 if above 9)
//   digit       : registered BCD digit
//   step_out    : carry/borrow to the next decade
// ---------------------------------------------------------------------------
module bcd_digit
    import contador_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic step_in,
    input  logic up,
    input  logic load,
    input  bcd_t ld_digit,
    output bcd_t digit,
    output logic step_out
);

    // This decade wraps (and passes the step on) only when it is being
    // stepped and sits at the limit for the current direction.
    assign step_out = step_in & (up ? (digit == BCD_MAX) : (digit == BCD_MIN));

    // Digit register: load beats stepping, stepping beats hold. Wrapping
    // at the limits gives the 9->0 / 0->9 behaviour of a decimal decade.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= BCD_MIN;
        end else if (load) begin
            digit <= bcd_clamp(ld_digit);
        end else if (step_in) begin
            if (up) begin
                digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
            end else begin
                digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/contador_bcd.sv
// ---------------------------------------------------------------------------
// contador_bcd
// Multi-decade BCD up/down counter with synchronous load and a one-cycle
// terminal-count pulse on wrap (all-9s -> all-0s up, all-0s -> all-9s down).
// Optional feature macro: CONTADOR_SEG7_EN adds the seg output.
// Parameters:
//   DIGITS      : number of decades, legal range 1..4
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : count enable, one step per edge
//   up          : direction, 1 = up, 0 = down
//   load        : synchronous load strobe (highest priority)
//   load_val    : BCD value to load, digit 0 in [3:0]
//   count       : registered BCD count, digit 0 in [3:0]
//   tc          : registered terminal-count pulse
//   seg         : (CONTADOR_SEG7_EN only) 7-segment gfedcba per digit,
//                 digit 0 in [6:0]
// ---------------------------------------------------------------------------
module contador_bcd
    import contador_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc
`ifdef CONTADOR_SEG7_EN
    ,
    output logic [7*DIGITS-1:0]   seg
`endif
);

    // step[i] feeds decade i; step[DIGITS] is the carry/borrow out of the
    // most significant decade, i.e. the whole counter is wrapping.
    logic [DIGITS:0] step;

    assign step[0] = en;

    // Decade chain: each cell's carry/borrow drives the next cell's step.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .step_in  (step[i]),
            .up       (up),
            .load     (load),
            .ld_digit (load_val[4*i +: 4]),
            .digit    (count[4*i +: 4]),
            .step_out (step[i+1])
        );
    end

    // Terminal count: registered so it lines up with the wrapped count.
    // A load takes priority over stepping, so it must never flag a wrap
    // even if the ripple chain happens to be fully propagated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc <= 1'b0;
        end else begin
            tc <= step[DIGITS] & ~load;
        end
    end

`ifdef CONTADOR_SEG7_EN
    // Display decode: driven straight from the count registers so the
    // pattern changes in the same cycle as count and shows 0s in reset.
    always_comb begin
        seg = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg[7*i +: 7] = seg7_decode(count[4*i +: 4]);
        end
    end
`endif

endmodule

// File: tb/tb_contador_bcd.sv
// ---------------------------------------------------------------------------
// tb_contador_bcd
// Self-checking bench for contador_bcd with DIGITS=2: a table of directed
// vectors, hand-written reset sequences, and a randomized run compared
// against an integer (0..99) model of the counter.
// ---------------------------------------------------------------------------
module tb_contador_bcd;

    localparam int DIGITS = 2;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic                up;
    logic                load;
    logic [4*DIGITS-1:0] load_val;
    logic [4*DIGITS-1:0] count;
    logic                tc;
`ifdef CONTADOR_SEG7_EN
    logic [7*DIGITS-1:0] seg;
`endif

    int tests;
    int failed;

    // Reference model state: plain decimal value and the expected tc.
    int   m_val;
    logic m_tc;

    typedef struct {
        string      name;
        logic       ld;
        logic       en;
        logic       up;
        logic [7:0] lv;
        logic [7:0] exp_count;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[$];

    contador_bcd #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc)
`ifdef CONTADOR_SEG7_EN
        ,
        .seg      (seg)
`endif
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int min9(input logic [3:0] d);
        return (int'(d) > 9) ? 9 : int'(d);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    // Decimal behaviour of one clock edge, written as arithmetic mod 100.
    task automatic modelEdge(input logic ld, input logic e, input logic u,
                             input logic [7:0] lv);
        if (ld) begin
            m_val = 10 * min9(lv[7:4]) + min9(lv[3:0]);
            m_tc  = 1'b0;
        end else if (e) begin
            if (u) begin
                m_tc  = (m_val == 99);
                m_val = (m_val + 1) % 100;
            end else begin
                m_tc  = (m_val == 0);
                m_val = (m_val + 99) % 100;
            end
        end else begin
            m_tc = 1'b0;
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, sample #1 later.
    task automatic applyStimulus(input logic ld, input logic e, input logic u,
                                 input logic [7:0] lv);
        load     = ld;
        en       = e;
        up       = u;
        load_val = lv;
        @(posedge clk);
        modelEdge(ld, e, u, lv);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp_count,
                               input logic exp_tc);
        tests++;
        if (count !== exp_count) begin
            failed++;
            $display("[TB] FAIL %s count: got %h, expected %h", name, count, exp_count);
        end
        tests++;
        if (tc !== exp_tc) begin
            failed++;
            $display("[TB] FAIL %s tc: got %b, expected %b", name, tc, exp_tc);
        end
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        m_val    = 0;
        m_tc     = 1'b0;
        rst_n    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = '0;

        // Directed vectors: {name, load, en, up, load_val, count, tc}.
        vecs.push_back('{"ld97",      1'b1, 1'b0, 1'b0, 8'h97, 8'h97, 1'b0});
        vecs.push_back('{"up98",      1'b0, 1'b1, 1'b1, 8'h00, 8'h98, 1'b0});
        vecs.push_back('{"up99",      1'b0, 1'b1, 1'b1, 8'h00, 8'h99, 1'b0});
        vecs.push_back('{"upwrap00",  1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{"up01",      1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b0});
        vecs.push_back('{"dn00",      1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{"dnwrap99",  1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1});
        vecs.push_back('{"dn98",      1'b0, 1'b1, 1'b0, 8'h00, 8'h98, 1'b0});
        vecs.push_back('{"hold98",    1'b0, 1'b0, 1'b0, 8'h00, 8'h98, 1'b0});
        vecs.push_back('{"ldC5",      1'b1, 1'b1, 1'b1, 8'hC5, 8'h95, 1'b0});
        vecs.push_back('{"ld99",      1'b1, 1'b0, 1'b1, 8'h99, 8'h99, 1'b0});
        vecs.push_back('{"ld00at99",  1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{"ld09",      1'b1, 1'b0, 1'b1, 8'h09, 8'h09, 1'b0});
        vecs.push_back('{"dirup10",   1'b0, 1'b1, 1'b1, 8'h00, 8'h10, 1'b0});
        vecs.push_back('{"dirdn09",   1'b0, 1'b1, 1'b0, 8'h00, 8'h09, 1'b0});
        vecs.push_back('{"ldAF",      1'b1, 1'b0, 1'b0, 8'hAF, 8'h99, 1'b0});
        vecs.push_back('{"wrapup",    1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1});
        vecs.push_back('{"tcclears",  1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0});
        vecs.push_back('{"ld3A",      1'b1, 1'b1, 1'b0, 8'h3A, 8'h39, 1'b0});
        vecs.push_back('{"dn38",      1'b0, 1'b1, 1'b0, 8'h00, 8'h38, 1'b0});

        // Reset state, checked with no clock edge needed.
        #12;
        checkOutput("reset", 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].lv);
            checkOutput(vecs[i].name, vecs[i].exp_count, vecs[i].exp_tc);
        end

`ifdef CONTADOR_SEG7_EN
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h42);
        tests++;
        if (seg !== 14'b1100110_1011011) begin
            failed++;
            $display("[TB] FAIL seg42: got %b, expected %b", seg, 14'b1100110_1011011);
        end
`endif

        // Reset mid-count at 37 with a load pending: count/tc clear at once,
        // and the pending load is discarded.
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h36);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("pre_reset37", 8'h37, 1'b0);
        load     = 1'b1;
        load_val = 8'h55;
        en       = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        m_val = 0;
        m_tc  = 1'b0;
        #1;
        checkOutput("reset_release", 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
        checkOutput("first_step", 8'h01, 1'b0);

        // Randomized run against the decimal model; loads favour the
        // wrap boundaries so tc gets exercised.
        for (int n = 0; n < 400; n++) begin
            logic       r_ld;
            logic       r_en;
            logic       r_up;
            logic [7:0] r_lv;
            int         pick;
            r_ld = ($urandom_range(0, 7) == 0);
            r_en = ($urandom_range(0, 3) != 0);
            r_up = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 3);
            if (pick == 0) begin
                r_lv = 8'h99;
            end else if (pick == 1) begin
                r_lv = 8'h00;
            end else begin
                r_lv = 8'($urandom);
            end
            applyStimulus(r_ld, r_en, r_up, r_lv);
            checkOutput("random", to_bcd(m_val), m_tc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/contador_bcd.md
CONTADOR_BCD -- requirements
Module: contador_bcd

Interface
REQ-001 Parameter DIGITS, default 2: number of BCD decades; legal range 1..4.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  count enable; one step per clk edge while high.
REQ-005 up  input  1  direction: 1 = count up, 0 = count down.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_val  input  4*DIGITS  BCD value to load; digit 0 in bits [3:0].
REQ-008 count  output  4*DIGITS  registered BCD count; digit 0 in bits [3:0].
REQ-009 tc  output  1  registered terminal-count pulse.

Function
REQ-010 Priority per edge SHALL be: load, then en, then hold.
REQ-011 With load=1, count SHALL take load_val on the next edge, regardless of en and up.
REQ-012 Any load_val digit above 9 SHALL be stored as 9; other digits SHALL be unaffected.
REQ-013 With load=0, en=1, up=1, count SHALL increment by one decimal unit.
REQ-014 Up-count carry SHALL ripple: a digit at 9 SHALL go to 0 and increment the next digit, all within the same edge.
REQ-015 With load=0, en=1, up=0, count SHALL decrement by one decimal unit.
REQ-016 Down-count borrow SHALL ripple: a digit at 0 SHALL go to 9 and decrement the next digit, all within the same edge.
REQ-017 Up wrap: all-9s SHALL go to all-0s.
REQ-018 Down wrap: all-0s SHALL go to all-9s.
REQ-019 tc SHALL be high for exactly the one cycle following an edge on which a wrap (REQ-017/018) occurred; it SHALL be low otherwise.
REQ-020 A load SHALL never assert tc, even when load_val equals the wrap target.
REQ-021 With en=0 and load=0, count and tc SHALL hold, except that tc SHALL clear after its single cycle.
REQ-022 A change of up SHALL take effect on the first edge on which it is sampled; there SHALL be no extra latency or skipped step.
REQ-023 Latency from an input change to the count/tc update SHALL be exactly one clk edge.

Reset
REQ-024 While rst_n=0, count SHALL be all-0s and tc SHALL be 0, immediately and independent of clk.
REQ-025 Reset asserted mid-count SHALL discard any pending load or step.
REQ-026 After rst_n deasserts, the first count update SHALL occur on the next clk rising edge.

Configuration
REQ-027 Macro CONTADOR_SEG7_EN: when defined, output seg (7*DIGITS, active-high, bit order gfedcba per digit) SHALL present the registered 7-segment decode of count.
REQ-028 seg SHALL change in the same cycle as count; reset value SHALL be the pattern for 0 on every digit.
REQ-029 Without CONTADOR_SEG7_EN, seg SHALL be absent and no decode logic SHALL be synthesised; all other behaviour SHALL be identical.

Structure
REQ-030 Shared package contador_pkg SHALL hold:
- BCD_MAX (9) and BCD_MIN (0)
- the 4-bit BCD digit type
- the 7-segment pattern table for digits 0-9
REQ-031 A sub-module bcd_digit SHALL implement one decade cell:
- inputs: step_in, up, load, ld_digit
- outputs: digit, step_out (carry or borrow)
REQ-032 contador_bcd SHALL instantiate DIGITS bcd_digit cells chained by step_out -> step_in, and SHALL derive tc from the last cell's step_out.

Verification (DIGITS=2)
REQ-033 Reset mid-count at 37 -> count=00 and tc=0 immediately; first step follows the next edge after release.
REQ-034 en=1, up=1 from 97 for 4 edges -> 98, 99, 00, 01; tc high only in the cycle showing 00.
REQ-035 en=1, up=0 from 01 for 3 edges -> 00, 99, 98; tc high only in the cycle showing 99.
REQ-036 load=1, en=1, load_val=0xC5 -> count=95 next cycle, tc=0; load_val=0x00 loaded at 99 -> count=00, tc=0.
REQ-037 en=1, up toggled 1->0 at count 09 -> 10 then 09, with no skipped value.
REQ-038 With CONTADOR_SEG7_EN, count=42 -> seg digit1=1100110, digit0=1011011.
